// File: rtl/data_split_seq.sv
// data_split_seq
//   Accepts one NWORDS*WORD_W record through a valid/ready handshake and emits
//   its fields one per clock on a single WORD_W output stream, also valid/ready.
//   Supports back-pressure, zero-bubble back-to-back records and a synchronous
//   abort that discards the record being emitted.
//
// Ports
//   Clk        in   single rising-edge clock
//   ResetB     in   asynchronous active-low reset
//   Data       in   input record, word k = Data[k*WORD_W +: WORD_W]
//   DataValid  in   Data is valid
//   DataReady  out  record accepted this cycle (combinational from WordReady)
//   Abort      in   synchronous, discards the current record
//   Word       out  current output word (registered)
//   WordValid  out  Word is valid
//   WordReady  in   downstream accepts Word
//   WordIndex  out  emission position of Word, 0..NWORDS-1
//   LastWord   out  Word is the final word of its record
//
// Build option
//   DATA_SPLIT_MSB_FIRST_EN  defined: emit word NWORDS-1 first; undefined: word 0 first.
//   WordIndex always counts in emission order.

module data_split_seq #(
    parameter int unsigned WORD_W = 12,
    parameter int unsigned NWORDS = 3,
    parameter int unsigned IDX_W  = 4
) (
    input  logic                     Clk,
    input  logic                     ResetB,
    input  logic [NWORDS*WORD_W-1:0] Data,
    input  logic                     DataValid,
    output logic                     DataReady,
    input  logic                     Abort,
    output logic [WORD_W-1:0]        Word,
    output logic                     WordValid,
    input  logic                     WordReady,
    output logic [IDX_W-1:0]         WordIndex,
    output logic                     LastWord
);

    localparam int unsigned REC_W = NWORDS * WORD_W;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NWORDS - 1);

    typedef enum logic {StIdle, StEmit} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [REC_W-1:0]    hold_q, hold_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                last_q, last_d;
    // Keeps DataReady low until the first edge after reset release.
    logic                rdy_en_q;

    logic                busy;
    logic                in_xfer;
    logic                out_xfer;

    // Field of rec emitted at position pos, honouring the emission order.
    function automatic logic [WORD_W-1:0] field(input logic [REC_W-1:0] rec,
                                                input logic [IDX_W-1:0] pos);
        logic [IDX_W-1:0]  sel;
        logic [WORD_W-1:0] f;
`ifdef DATA_SPLIT_MSB_FIRST_EN
        sel = LastIdx - pos;
`else
        sel = pos;
`endif
        f = '0;
        for (int k = 0; k < int'(NWORDS); k++) begin
            if (sel == IDX_W'(k)) begin
                f = rec[k*WORD_W +: WORD_W];
            end
        end
        return f;
    endfunction

    // State register
    always_ff @(posedge Clk or negedge ResetB) begin
        if (!ResetB) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge Clk or negedge ResetB) begin
        if (!ResetB) begin
            idx_q    <= '0;
            hold_q   <= '0;
            word_q   <= '0;
            last_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            word_q   <= word_d;
            last_q   <= last_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        word_d  = word_q;

        if (Abort) begin
            state_d = StIdle;
            idx_d   = '0;
        end else if (in_xfer) begin
            // Covers both an idle load and a load overlapping the last word.
            state_d = StEmit;
            hold_d  = Data;
            idx_d   = '0;
            word_d  = field(Data, '0);
        end else if (out_xfer) begin
            if (last_q) begin
                state_d = StIdle;
            end else begin
                idx_d  = idx_q + 1'b1;
                word_d = field(hold_q, idx_q + 1'b1);
            end
        end

        last_d = (state_d == StEmit) && (idx_d == LastIdx);
    end

    // Outputs
    always_comb begin
        busy      = (state_q == StEmit);
        WordValid = busy;
        Word      = word_q;
        WordIndex = idx_q;
        LastWord  = last_q;
        out_xfer  = busy & WordReady;
        DataReady = rdy_en_q & ~Abort & (~busy | (out_xfer & last_q));
        in_xfer   = DataValid & DataReady;
    end

endmodule

// File: tb/tb_data_split_seq.sv
module tb_data_split_seq;

    logic        Clk;
    logic        ResetB;

    // Default-parameter instance
    logic [35:0] Data;
    logic        DataValid;
    logic        DataReady;
    logic        Abort;
    logic [11:0] Word;
    logic        WordValid;
    logic        WordReady;
    logic [3:0]  WordIndex;
    logic        LastWord;

    // WORD_W=8, NWORDS=5 instance
    logic [39:0] b_data;
    logic        b_dvalid;
    logic        b_dready;
    logic        b_abort;
    logic [7:0]  b_word;
    logic        b_wvalid;
    logic        b_wready;
    logic [3:0]  b_idx;
    logic        b_last;

    int n_checks = 0;
    int n_errors = 0;

    data_split_seq dut (
        .Clk       (Clk),
        .ResetB    (ResetB),
        .Data      (Data),
        .DataValid (DataValid),
        .DataReady (DataReady),
        .Abort     (Abort),
        .Word      (Word),
        .WordValid (WordValid),
        .WordReady (WordReady),
        .WordIndex (WordIndex),
        .LastWord  (LastWord)
    );

    data_split_seq #(
        .WORD_W (8),
        .NWORDS (5),
        .IDX_W  (4)
    ) dut_b (
        .Clk       (Clk),
        .ResetB    (ResetB),
        .Data      (b_data),
        .DataValid (b_dvalid),
        .DataReady (b_dready),
        .Abort     (b_abort),
        .Word      (b_word),
        .WordValid (b_wvalid),
        .WordReady (b_wready),
        .WordIndex (b_idx),
        .LastWord  (b_last)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // k-th emitted field of a 3x12 record
    function automatic logic [11:0] fa(input logic [35:0] r, input int k);
        logic [35:0] t;
        t = r;
`ifdef DATA_SPLIT_MSB_FIRST_EN
        return t[(2-k)*12 +: 12];
`else
        return t[k*12 +: 12];
`endif
    endfunction

    // k-th emitted field of a 5x8 record
    function automatic logic [7:0] fb(input logic [39:0] r, input int k);
        logic [39:0] t;
        t = r;
`ifdef DATA_SPLIT_MSB_FIRST_EN
        return t[(4-k)*8 +: 8];
`else
        return t[k*8 +: 8];
`endif
    endfunction

    task automatic chk_out(input string tag, input logic [11:0] w, input int idx,
                           input logic last);
        check_eq({tag, ".valid"}, 64'(WordValid), 64'(1));
        check_eq({tag, ".word"}, 64'(Word), 64'(w));
        check_eq({tag, ".idx"}, 64'(WordIndex), 64'(idx));
        check_eq({tag, ".last"}, 64'(LastWord), 64'(last));
    endtask

    // Sweep scoreboard: entries are {last, idx, word}
    logic [12:0] sb_q[$];
    int          b_recs  = 0;
    int          b_words = 0;
    logic        b_acc   = 1'b0;

    task automatic b_sample();
        logic [12:0] e;
        b_acc = b_dvalid & b_dready;
        if (b_wvalid & b_wready) begin
            b_words++;
            check_eq("sw.pending", 64'(sb_q.size() > 0), 64'(1));
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_eq("sw.word", 64'({b_last, b_idx, b_word}), 64'(e));
            end
        end
        if (b_acc) begin
            b_recs++;
            for (int k = 0; k < 5; k++) begin
                sb_q.push_back({(k == 4), 4'(k), fb(b_data, k)});
            end
        end
    endtask

    localparam logic [35:0] R1 = 36'hABCDEF123;
    localparam logic [35:0] RA = 36'h456789ABC;
    localparam logic [35:0] RB = 36'h0FEDCBA98;
    localparam logic [35:0] RC = 36'h111222333;
    localparam logic [35:0] RD = 36'h777888999;
    localparam logic [35:0] RE = 36'h555666444;

    initial begin
        logic [63:0] rnd;

        ResetB    = 1'b0;
        Data      = '0;
        DataValid = 1'b0;
        Abort     = 1'b0;
        WordReady = 1'b1;
        b_data    = '0;
        b_dvalid  = 1'b0;
        b_abort   = 1'b0;
        b_wready  = 1'b1;

        // Reset state
        #2;
        check_eq("rst.word", 64'(Word), 64'(0));
        check_eq("rst.valid", 64'(WordValid), 64'(0));
        check_eq("rst.idx", 64'(WordIndex), 64'(0));
        check_eq("rst.last", 64'(LastWord), 64'(0));
        check_eq("rst.ready", 64'(DataReady), 64'(0));
        @(negedge Clk);
        ResetB = 1'b1;
        #1;
        check_eq("rst.ready_before_edge", 64'(DataReady), 64'(0));
        tick();
        check_eq("rst.ready_after_edge", 64'(DataReady), 64'(1));

        // Single record
        Data      = R1;
        DataValid = 1'b1;
        tick();
        DataValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_out("single", fa(R1, k), k, (k == 2));
            check_eq("single.ready", 64'(DataReady), 64'(k == 2));
            tick();
        end
        check_eq("single.idle", 64'(WordValid), 64'(0));

        // Back-to-back
        Data      = RA;
        DataValid = 1'b1;
        tick();
        Data = RB;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_out("b2b.a", fa(RA, k), k, (k == 2));
            check_eq("b2b.ready", 64'(DataReady), 64'(k == 2));
            tick();
        end
        DataValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_out("b2b.b", fa(RB, k), k, (k == 2));
            tick();
        end
        check_eq("b2b.idle", 64'(WordValid), 64'(0));

        // Back-pressure on word 1
        Data      = R1;
        DataValid = 1'b1;
        tick();
        DataValid = 1'b0;
        chk_out("bp.w0", fa(R1, 0), 0, 1'b0);
        tick();
        WordReady = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk_out("bp.stall", fa(R1, 1), 1, 1'b0);
            check_eq("bp.ready", 64'(DataReady), 64'(0));
            tick();
        end
        WordReady = 1'b1;
        #1;
        chk_out("bp.w1", fa(R1, 1), 1, 1'b0);
        tick();
        chk_out("bp.w2", fa(R1, 2), 2, 1'b1);
        tick();
        check_eq("bp.idle", 64'(WordValid), 64'(0));

        // Abort during word 1, with a new record offered at the same time
        Data      = RC;
        DataValid = 1'b1;
        tick();
        DataValid = 1'b0;
        tick();
        Abort     = 1'b1;
        Data      = RD;
        DataValid = 1'b1;
        #1;
        check_eq("ab.ready_blocked", 64'(DataReady), 64'(0));
        chk_out("ab.w1", fa(RC, 1), 1, 1'b0);
        tick();
        Abort = 1'b0;
        #1;
        check_eq("ab.valid", 64'(WordValid), 64'(0));
        check_eq("ab.idx", 64'(WordIndex), 64'(0));
        check_eq("ab.last", 64'(LastWord), 64'(0));
        check_eq("ab.ready", 64'(DataReady), 64'(1));
        tick();
        DataValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_out("ab.new", fa(RD, k), k, (k == 2));
            tick();
        end
        check_eq("ab.idle", 64'(WordValid), 64'(0));

        // Reset mid-record
        Data      = RE;
        DataValid = 1'b1;
        tick();
        DataValid = 1'b0;
        tick();
        ResetB = 1'b0;
        #1;
        check_eq("mrst.word", 64'(Word), 64'(0));
        check_eq("mrst.valid", 64'(WordValid), 64'(0));
        check_eq("mrst.idx", 64'(WordIndex), 64'(0));
        check_eq("mrst.last", 64'(LastWord), 64'(0));
        check_eq("mrst.ready", 64'(DataReady), 64'(0));
        @(negedge Clk);
        ResetB = 1'b1;
        tick();
        check_eq("mrst.ready_after", 64'(DataReady), 64'(1));
        for (int i = 0; i < 4; i++) begin
            check_eq("mrst.no_residual", 64'(WordValid), 64'(0));
            tick();
        end

        // Parameter sweep: random records and random back-pressure
        for (int cyc = 0; cyc < 400; cyc++) begin
            b_wready = ($urandom_range(0, 3) != 0);
            if (!b_dvalid || b_acc) begin
                b_dvalid = ($urandom_range(0, 2) != 0);
                rnd      = {$urandom(), $urandom()};
                b_data   = rnd[39:0];
            end
            @(negedge Clk);
            b_sample();
            tick();
        end
        b_dvalid = 1'b0;
        b_wready = 1'b1;
        for (int i = 0; i < 40 && sb_q.size() > 0; i++) begin
            @(negedge Clk);
            b_sample();
            tick();
        end
        check_eq("sw.drained", 64'(sb_q.size()), 64'(0));
        check_eq("sw.count", 64'(b_words), 64'(b_recs * 5));
        check_eq("sw.idle", 64'(b_wvalid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_split_seq.md
# data_split_seq

Parametrised successor to the fixed 36-to-3×12 data splitter. It accepts one wide record of `NWORDS` fields through a valid/ready handshake and emits the fields one per clock on a single `WORD_W`-bit output, also with valid/ready. It sits between the readout record FIFO and the 12-bit word-to-serialiser path, replacing the static 3-bus fan-out with a time-multiplexed stream. It supports back-pressure, back-to-back records and a synchronous abort.

## Interface
Parameters:
- `WORD_W`, 12, width of one output word.
- `NWORDS`, 3, words per record; legal range 2..16.
- `IDX_W`, 4, width of `WordIndex`; must satisfy 2^`IDX_W` ≥ `NWORDS`.

Ports:
- `Clk`  in  1  single clock; all logic is rising-edge.
- `ResetB`  in  1  asynchronous, active-low reset.
- `Data`  in  `NWORDS*WORD_W`  input record; word k is `Data[k*WORD_W +: WORD_W]`.
- `DataValid`  in  1  `Data` is valid.
- `DataReady`  out  1  block accepts `Data` this cycle.
- `Abort`  in  1  synchronous; discards the record being emitted.
- `Word`  out  `WORD_W`  current output word (registered).
- `WordValid`  out  1  `Word` is valid.
- `WordReady`  in  1  downstream accepts `Word`.
- `WordIndex`  out  `IDX_W`  position of `Word` within its record, 0..`NWORDS`-1, in emission order.
- `LastWord`  out  1  `Word` is the final word of its record.

## Operation
- Internal state:
  - record holding register `Hold` (`NWORDS*WORD_W` bits);
  - index counter `Idx` (`IDX_W` bits);
  - busy flag.
- Two states:
  - **IDLE**: busy=0, `WordValid`=0.
  - **EMIT**: busy=1, `WordValid`=1.
- Handshakes:
  - Input transfer occurs when `DataValid`&`DataReady`.
  - Output transfer occurs when `WordValid`&`WordReady`.
- `DataReady` = !busy | (output transfer & `LastWord`). This is a combinational path from `WordReady` and allows zero-bubble back-to-back records.
- On an input transfer:
  - `Hold` ← `Data`; `Idx` ← 0; next state EMIT.
  - `Word` ← the first field of the new record.
- On an output transfer that is not the last word: `Idx` ← `Idx`+1; `Word` ← the next field.
- On an output transfer of the last word:
  - with no simultaneous input transfer: next state IDLE, `WordValid` ← 0;
  - with a simultaneous input transfer: the new record loads as above.
- While `WordValid`=1 and `WordReady`=0: `Word`, `WordIndex` and `LastWord` hold stable.
- `WordIndex` = `Idx`. `LastWord` = (`Idx` == `NWORDS`-1) & `WordValid`.
- Abort:
  - If `Abort`=1, next state IDLE, `WordValid` ← 0 and `Idx` ← 0, regardless of `WordReady`.
  - `Abort` has priority over an input transfer, so `DataReady` is forced to 0 while `Abort`=1.
- Async reset (`ResetB`=0):
  - `Word`=0, `WordValid`=0, `WordIndex`=0, `LastWord`=0, `DataReady`=0, `Hold`=0, state IDLE.
  - `DataReady` rises to 1 on the first clock edge after `ResetB` deasserts.
  - Reset mid-record discards the record; no partial words are emitted afterwards.

## Timing
- Latency: input transfer at edge N puts the first word on `Word` with `WordValid`=1 after edge N.
- Throughput:
  - With `WordReady` held at 1, a record takes exactly `NWORDS` cycles.
  - Back-to-back records produce a continuous word stream with no idle cycle.
- An isolated record leaves `WordValid`=0 one cycle after its last output transfer.
- All outputs except `DataReady` are registered.

## Configuration
- `DATA_SPLIT_MSB_FIRST_EN`:
  - Undefined: emission order is word 0 (LSBs) first.
  - Defined: emission order is word `NWORDS`-1 (MSBs) first.
- In both cases `WordIndex` counts 0..`NWORDS`-1 in emission order, and `LastWord` marks the final emitted word.

## Test plan
- **Single record, LSB-first:** defaults, `Data`=36'hABCDEF123, `WordReady`=1 → `Word`=12'h123, 12'hDEF, 12'hABC on 3 consecutive cycles; `WordIndex` 0,1,2; `LastWord` on the 3rd word only.
- **MSB-first build:** macro defined, same stimulus → `Word` order 12'hABC, 12'hDEF, 12'h123.
- **Back-to-back:** two records with `DataValid` held high → 6 contiguous valid words; `DataReady`=1 only in the cycle of the first record's last word.
- **Back-pressure:** `WordReady` low for 5 cycles during word 1 → `Word`=12'hDEF and `WordIndex`=1 stay stable; `DataReady`=0 throughout; completion follows when `WordReady` rises.
- **Abort and reset:**
  - `Abort` pulsed during word 1 → `WordValid`=0 next cycle, and a new record starts at index 0.
  - `ResetB` pulsed low mid-record → all outputs 0 immediately, with no residual words.
- **Parameter sweep:** `WORD_W`=8, `NWORDS`=5, random records and random `WordReady` → scoreboard matches field order and count exactly.
